// File: rtl/seq_alu.sv
// ----------------------------------------------------------------------------
// seq_alu -- registered, parametrised ALU with a Start/Busy/Done handshake.
//
// Single-cycle operations (MEM, IMM, ADD/ADC, SUB/SBC, AND/OR/XOR/NOT, NOP, and
// shifts by zero) write Result/Flags on the edge that accepts Start. Shifts by
// n >= 1 move one bit per clock and complete n edges later. With the optional
// multiplier built in, MUL is a shift-add multiply taking WIDTH edges.
//
// Optional feature macro: SEQ_ALU_MUL_EN
//   defined   -> AluOp 4'hD is an unsigned WIDTH-cycle shift-add multiply
//   undefined -> no multiplier; AluOp 4'hD behaves like MEM (Result = Op1)
//
// Parameters
//   WIDTH    datapath width (>= 4)
//   SHAMT_W  shift-amount width, taken from Op2[SHAMT_W-1:0]
//
// Ports
//   Clock   in   1      rising-edge clock
//   nReset  in   1      asynchronous active-low reset
//   Start   in   1      operation request, sampled only while Busy = 0
//   AluOp   in   4      operation select (0 MEM .. D MUL, E/F NOP)
//   Op1     in   WIDTH  operand A / shift source
//   Op2     in   WIDTH  operand B / shift amount
//   Result  out  WIDTH  registered result, held between operations
//   Flags   out  4      registered {N,V,C,Z}
//   Busy    out  1      multi-cycle operation in progress
//   Done    out  1      one-cycle pulse, Result/Flags updated on that edge
// ----------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Start,
  input  logic [3:0]       AluOp,
  input  logic [WIDTH-1:0] Op1,
  input  logic [WIDTH-1:0] Op2,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       Flags,
  output logic             Busy,
  output logic             Done
);

  // Counter must reach WIDTH for the multiply, hence one bit more than SHAMT_W.
  localparam int CNT_W = SHAMT_W + 1;

  localparam logic [3:0] OP_MEM = 4'h0;
  localparam logic [3:0] OP_IMM = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_ADC = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_SBC = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_LSL = 4'hA;
  localparam logic [3:0] OP_LSR = 4'hB;
  localparam logic [3:0] OP_ASR = 4'hC;
  localparam logic [3:0] OP_MUL = 4'hD;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic [3:0]         flags_reg, flags_next;
  logic               done_reg, done_next;
  logic [3:0]         op_reg, op_next;
  // Shift source during shifts; multiplier (consumed LSB first) during MUL.
  logic [WIDTH-1:0]   sh_reg, sh_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

`ifdef SEQ_ALU_MUL_EN
  logic [2*WIDTH-1:0] mcand_reg, mcand_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [2*WIDTH-1:0] acc_sum;
`endif

  // --------------------------------------------------------------------------
  // Single-cycle datapath, evaluated on the live inputs at the accepting edge.
  // --------------------------------------------------------------------------
  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  logic               cin;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     dif_ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;

  assign shamt    = Op2[SHAMT_W-1:0];
  assign is_shift = (AluOp == OP_LSL) || (AluOp == OP_LSR) || (AluOp == OP_ASR);

  always_comb begin
    // Only the carry-chained ops consume the registered carry.
    cin     = flags_reg[1] & ((AluOp == OP_ADC) || (AluOp == OP_SBC));
    sum_ext = {1'b0, Op1} + {1'b0, Op2} + {{WIDTH{1'b0}}, cin};
    // In WIDTH+1 bits the top bit of the difference is exactly the borrow.
    dif_ext = {1'b0, Op1} - {1'b0, Op2} - {{WIDTH{1'b0}}, cin};
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (AluOp)
      OP_MEM: alu_res = Op1;
      OP_IMM: alu_res = Op2;
      OP_ADD, OP_ADC: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (Op1[WIDTH-1] == Op2[WIDTH-1]) && (sum_ext[WIDTH-1] != Op1[WIDTH-1]);
      end
      OP_SUB, OP_SBC: begin
        alu_res = dif_ext[WIDTH-1:0];
        alu_c   = dif_ext[WIDTH];
        alu_v   = (Op1[WIDTH-1] != Op2[WIDTH-1]) && (dif_ext[WIDTH-1] != Op1[WIDTH-1]);
      end
      OP_AND: alu_res = Op1 & Op2;
      OP_OR:  alu_res = Op1 | Op2;
      OP_XOR: alu_res = Op1 ^ Op2;
      OP_NOT: alu_res = ~Op1;
      // Shift by zero completes at once with the source unchanged.
      OP_LSL, OP_LSR, OP_ASR: alu_res = Op1;
      // Without the multiplier, MUL falls back to MEM behaviour.
      OP_MUL: alu_res = Op1;
      default: alu_res = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // One-bit shift step on the captured source.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] shift_step;
  logic             shift_out;

  always_comb begin
    shift_step = sh_reg;
    shift_out  = 1'b0;
    case (op_reg)
      OP_LSL: begin
        shift_step = {sh_reg[WIDTH-2:0], 1'b0};
        shift_out  = sh_reg[WIDTH-1];
      end
      OP_LSR: begin
        shift_step = {1'b0, sh_reg[WIDTH-1:1]};
        shift_out  = sh_reg[0];
      end
      OP_ASR: begin
        shift_step = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
        shift_out  = sh_reg[0];
      end
      default: begin
        shift_step = sh_reg;
        shift_out  = 1'b0;
      end
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  // Add the shifted multiplicand when the current multiplier bit is set.
  assign acc_sum = sh_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
`endif

  // --------------------------------------------------------------------------
  // Next-state / next-output logic.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    flags_next  = flags_reg;
    done_next   = 1'b0;
    op_next     = op_reg;
    sh_next     = sh_reg;
    cnt_next    = cnt_reg;
`ifdef SEQ_ALU_MUL_EN
    mcand_next  = mcand_reg;
    acc_next    = acc_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (Start) begin
          op_next = AluOp;
          if (is_shift && (shamt != '0)) begin
            state_next = ST_SHIFT;
            sh_next    = Op1;
            cnt_next   = {1'b0, shamt};
          end
`ifdef SEQ_ALU_MUL_EN
          else if (AluOp == OP_MUL) begin
            state_next = ST_MUL;
            sh_next    = Op2;
            mcand_next = {{WIDTH{1'b0}}, Op1};
            acc_next   = '0;
            cnt_next   = CNT_W'(WIDTH);
          end
`endif
          else begin
            result_next = alu_res;
            flags_next  = {alu_res[WIDTH-1], alu_v, alu_c, (alu_res == '0)};
            done_next   = 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        sh_next  = shift_step;
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next  = ST_IDLE;
          result_next = shift_step;
          flags_next  = {shift_step[WIDTH-1], 1'b0, shift_out, (shift_step == '0)};
          done_next   = 1'b1;
        end
      end

`ifdef SEQ_ALU_MUL_EN
      ST_MUL: begin
        acc_next   = acc_sum;
        mcand_next = {mcand_reg[2*WIDTH-2:0], 1'b0};
        sh_next    = {1'b0, sh_reg[WIDTH-1:1]};
        cnt_next   = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next  = ST_IDLE;
          result_next = acc_sum[WIDTH-1:0];
          flags_next  = {acc_sum[WIDTH-1], 1'b0, (acc_sum[2*WIDTH-1:WIDTH] != '0),
                         (acc_sum[WIDTH-1:0] == '0)};
          done_next   = 1'b1;
        end
      end
`endif

      default: state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers. Reset abandons any in-flight operation.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_reg  <= ST_IDLE;
      result_reg <= '0;
      flags_reg  <= '0;
      done_reg   <= 1'b0;
      op_reg     <= '0;
      sh_reg     <= '0;
      cnt_reg    <= '0;
`ifdef SEQ_ALU_MUL_EN
      mcand_reg  <= '0;
      acc_reg    <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
      flags_reg  <= flags_next;
      done_reg   <= done_next;
      op_reg     <= op_next;
      sh_reg     <= sh_next;
      cnt_reg    <= cnt_next;
`ifdef SEQ_ALU_MUL_EN
      mcand_reg  <= mcand_next;
      acc_reg    <= acc_next;
`endif
    end
  end

  assign Result = result_reg;
  assign Flags  = flags_reg;
  assign Done   = done_reg;
  assign Busy   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_seq_alu.sv
// ----------------------------------------------------------------------------
// tb_seq_alu -- self-checking bench for seq_alu (WIDTH = 16).
// Directed table of vectors, hand-written handshake/reset sequences, and
// random operations checked against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_seq_alu;

  logic        Clock = 1'b0;
  logic        nReset;
  logic        Start;
  logic [3:0]  AluOp;
  logic [15:0] Op1;
  logic [15:0] Op2;
  logic [15:0] Result;
  logic [3:0]  Flags;
  logic        Busy;
  logic        Done;

  int asserts  = 0;
  int failures = 0;
  logic model_c = 1'b0;

  always #5 Clock = ~Clock;

  seq_alu #(.WIDTH(16)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .Start  (Start),
    .AluOp  (AluOp),
    .Op1    (Op1),
    .Op2    (Op2),
    .Result (Result),
    .Flags  (Flags),
    .Busy   (Busy),
    .Done   (Done)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation rules.
  task automatic ref_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, output logic [15:0] r, output logic [3:0] fl,
                           output int lat);
    longint ua, ub, sa, sb, t, s;
    longint ci;
    int n;
    logic c, v;
    logic signed [15:0] as16;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    as16 = a;
    n = int'(b[3:0]);
    c = 1'b0; v = 1'b0; lat = 0; r = '0;
    ci = (op == 4'h3 || op == 4'h5) ? longint'(cin) : 0;
    case (op)
      4'h0: r = a;
      4'h1: r = b;
      4'h2, 4'h3: begin
        t = ua + ub + ci; r = t[15:0]; c = (t > 65535);
        s = sa + sb + ci; v = (s > 32767) || (s < -32768);
      end
      4'h4, 4'h5: begin
        t = ua - ub - ci; r = t[15:0]; c = (ua < ub + ci);
        s = sa - sb - ci; v = (s > 32767) || (s < -32768);
      end
      4'h6: r = a & b;
      4'h7: r = a | b;
      4'h8: r = a ^ b;
      4'h9: r = ~a;
      4'hA: begin
        r = a << n; lat = n;
        if (n != 0) c = ((ua >> (16 - n)) & 1) != 0;
      end
      4'hB: begin
        r = a >> n; lat = n;
        if (n != 0) c = ((ua >> (n - 1)) & 1) != 0;
      end
      4'hC: begin
        r = as16 >>> n; lat = n;
        if (n != 0) c = ((ua >> (n - 1)) & 1) != 0;
      end
      4'hD: begin
`ifdef SEQ_ALU_MUL_EN
        t = ua * ub; r = t[15:0]; c = (t[31:16] != 0); lat = 16;
`else
        r = a;
`endif
      end
      default: r = '0;
    endcase
    fl = {r[15], v, c, (r == 16'h0)};
  endtask

  // Issue one operation, wait for Done (bounded), return what was observed.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] res, output logic [3:0] fl, output int lat,
                        output logic busy0, output logic busy_end, output logic ok);
    @(negedge Clock);
    Start = 1'b1; AluOp = op; Op1 = a; Op2 = b;
    @(posedge Clock); #1;
    // Scramble inputs: an accepted op must not depend on them any more.
    Start = 1'b0; Op1 = ~a; Op2 = ~b; AluOp = ~op;
    busy0 = Busy;
    lat = 0;
    while (!Done && lat < 40) begin
      @(posedge Clock); #1;
      lat++;
    end
    ok = Done; res = Result; fl = Flags; busy_end = Busy;
  endtask

  task automatic do_check(input string name, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] eres, input logic [3:0] efl,
                          input int elat);
    logic [15:0] res; logic [3:0] fl; int lat; logic b0, be, ok;
    run_op(op, a, b, res, fl, lat, b0, be, ok);
    $display("%s op=%h a=%h b=%h -> res=%h flags=%b lat=%0d (exp %h %b %0d)",
             name, op, a, b, res, fl, lat, eres, efl, elat);
    chk({name, " done"}, 32'(ok), 32'd1);
    chk({name, " result"}, 32'(res), 32'(eres));
    chk({name, " flags"}, 32'(fl), 32'(efl));
    chk({name, " latency"}, 32'(lat), 32'(elat));
    chk({name, " busy_after_e0"}, 32'(b0), (elat != 0) ? 32'd1 : 32'd0);
    chk({name, " busy_at_done"}, 32'(be), 32'd0);
    @(posedge Clock); #1;
    chk({name, " done_pulse"}, 32'(Done), 32'd0);
    model_c = efl[1];
  endtask

  initial begin
    logic [15:0] eres; logic [3:0] efl; int elat; int k;
    logic [3:0] op; logic [15:0] a, b;

    Start = 1'b0; AluOp = 4'h0; Op1 = '0; Op2 = '0;
    nReset = 1'b1;
    #2 nReset = 1'b0;
    #2;
    chk("reset result", 32'(Result), 32'd0);
    chk("reset flags", 32'(Flags), 32'd0);
    chk("reset busy", 32'(Busy), 32'd0);
    chk("reset done", 32'(Done), 32'd0);
    repeat (2) @(posedge Clock);
    @(negedge Clock) nReset = 1'b1;
    model_c = 1'b0;

    // {op, a, b, result, {N,V,C,Z}, latency}; order matters for carry-in.
    tbl.push_back(vec_t'{4'h2, 16'h7FFF, 16'h0001, 16'h8000, 4'b1100, 0});
    tbl.push_back(vec_t'{4'h2, 16'hFFFF, 16'h0001, 16'h0000, 4'b0011, 0});
    tbl.push_back(vec_t'{4'h3, 16'h0001, 16'h0001, 16'h0003, 4'b0000, 0});
    tbl.push_back(vec_t'{4'h4, 16'h0003, 16'h0005, 16'hFFFE, 4'b1010, 0});
    tbl.push_back(vec_t'{4'h4, 16'h8000, 16'h0001, 16'h7FFF, 4'b0100, 0});
    tbl.push_back(vec_t'{4'h4, 16'h0000, 16'h0001, 16'hFFFF, 4'b1010, 0});
    tbl.push_back(vec_t'{4'h5, 16'h0005, 16'h0002, 16'h0002, 4'b0000, 0});
    tbl.push_back(vec_t'{4'h6, 16'hF0F0, 16'hFF00, 16'hF000, 4'b1000, 0});
    tbl.push_back(vec_t'{4'h7, 16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000, 0});
    tbl.push_back(vec_t'{4'h8, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0001, 0});
    tbl.push_back(vec_t'{4'h9, 16'h00FF, 16'h1234, 16'hFF00, 4'b1000, 0});
    tbl.push_back(vec_t'{4'h0, 16'h1234, 16'h5678, 16'h1234, 4'b0000, 0});
    tbl.push_back(vec_t'{4'h1, 16'h1234, 16'h5678, 16'h5678, 4'b0000, 0});
    tbl.push_back(vec_t'{4'hA, 16'h8001, 16'h0003, 16'h0008, 4'b0000, 3});
    tbl.push_back(vec_t'{4'hC, 16'h8000, 16'h000F, 16'hFFFF, 4'b1000, 15});
    tbl.push_back(vec_t'{4'hB, 16'h8001, 16'h0000, 16'h8001, 4'b1000, 0});
    tbl.push_back(vec_t'{4'hB, 16'h8001, 16'h0001, 16'h4000, 4'b0010, 1});
    tbl.push_back(vec_t'{4'hE, 16'h1234, 16'h5678, 16'h0000, 4'b0001, 0});
    tbl.push_back(vec_t'{4'hA, 16'h8001, 16'h0001, 16'h0002, 4'b0010, 1});
    tbl.push_back(vec_t'{4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0001, 0});
`ifdef SEQ_ALU_MUL_EN
    tbl.push_back(vec_t'{4'hD, 16'h0012, 16'h0034, 16'h03A8, 4'b0000, 16});
    tbl.push_back(vec_t'{4'hD, 16'h0100, 16'h0100, 16'h0000, 4'b0011, 16});
`else
    tbl.push_back(vec_t'{4'hD, 16'h0012, 16'h0034, 16'h0012, 4'b0000, 0});
    tbl.push_back(vec_t'{4'hD, 16'h8100, 16'h0100, 16'h8100, 4'b1000, 0});
`endif

    foreach (tbl[i])
      do_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
               tbl[i].res, tbl[i].fl, tbl[i].lat);

    // Start pulsed while a shift is in flight must be ignored.
    @(negedge Clock);
    Start = 1'b1; AluOp = 4'hA; Op1 = 16'h0001; Op2 = 16'h0005;
    @(posedge Clock); #1;
    Start = 1'b0; Op1 = 16'hFFFF;
    k = 0;
    while (!Done && k < 40) begin
      if (k == 1) begin
        Start = 1'b1; AluOp = 4'h2; Op1 = 16'h0002; Op2 = 16'h0002;
      end else begin
        Start = 1'b0;
      end
      @(posedge Clock); #1;
      k++;
    end
    Start = 1'b0;
    $display("midstart LSL 0001 by 5 -> res=%h flags=%b lat=%0d", Result, Flags, k);
    chk("midstart latency", 32'(k), 32'd5);
    chk("midstart result", 32'(Result), 32'h0020);
    chk("midstart flags", 32'(Flags), 32'h0);
    @(posedge Clock); #1;
    chk("midstart no_extra_done", 32'(Done), 32'd0);
    chk("midstart no_extra_busy", 32'(Busy), 32'd0);
    chk("midstart result_held", 32'(Result), 32'h0020);

    // Back-to-back issue in the Done cycle.
    @(negedge Clock);
    Start = 1'b1; AluOp = 4'hB; Op1 = 16'h00F0; Op2 = 16'h0002;
    @(posedge Clock); #1;
    Start = 1'b0;
    k = 0;
    while (!Done && k < 40) begin
      @(posedge Clock); #1;
      k++;
    end
    $display("b2b LSR 00F0 by 2 -> res=%h flags=%b lat=%0d", Result, Flags, k);
    chk("b2b shift latency", 32'(k), 32'd2);
    chk("b2b shift result", 32'(Result), 32'h003C);
    Start = 1'b1; AluOp = 4'h2; Op1 = 16'h0002; Op2 = 16'h0003;
    @(posedge Clock); #1;
    Start = 1'b0;
    $display("b2b ADD 0002+0003 -> res=%h flags=%b done=%b", Result, Flags, Done);
    chk("b2b add done", 32'(Done), 32'd1);
    chk("b2b add result", 32'(Result), 32'h0005);
    chk("b2b add flags", 32'(Flags), 32'h0);

    // Asynchronous reset in the middle of a 10-cycle shift.
    @(negedge Clock);
    Start = 1'b1; AluOp = 4'hA; Op1 = 16'h00FF; Op2 = 16'h000A;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (4) @(posedge Clock);
    #1;
    chk("midreset busy_before", 32'(Busy), 32'd1);
    #1 nReset = 1'b0;
    #1;
    $display("midreset -> res=%h flags=%b busy=%b done=%b", Result, Flags, Busy, Done);
    chk("midreset result", 32'(Result), 32'd0);
    chk("midreset flags", 32'(Flags), 32'd0);
    chk("midreset busy", 32'(Busy), 32'd0);
    chk("midreset done", 32'(Done), 32'd0);
    @(posedge Clock);
    @(negedge Clock) nReset = 1'b1;
    model_c = 1'b0;
    do_check("post_reset", 4'h2, 16'h0002, 16'h0002, 16'h0004, 4'b0000, 0);

    // Random operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if ((i % 5) == 0) b = 16'($urandom_range(0, 3));
      ref_model(op, a, b, model_c, eres, efl, elat);
      do_check($sformatf("rnd%0d", i), op, a, b, eres, efl, elat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

  // Absolute time guard so the run always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, failures so far %0d", failures);
    $fatal(1, "timeout");
  end

endmodule
